// File: rtl/fifo_sync.sv
// ============================================================================
// Module   : fifo_sync
// Desc     : Single-clock FIFO with registered read data and count-based flags.
//            Optional sticky overflow/underflow flags under FIFO_ERR_FLAGS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_sync #(
  parameter int fifo_depth = 8,
  parameter int fifo_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  fifo_write,
  input  logic                  fifo_read,
  input  logic [fifo_width-1:0] fifo_data_in,
  output logic [fifo_width-1:0] fifo_data_out,
  output logic                  fifo_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  fifo_overflow,
  output logic                  fifo_underflow,
`endif
  output logic                  fifo_empty
);

  localparam int                 c_aw   = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [c_aw:0]      c_full = (c_aw+1)'(fifo_depth);
  localparam logic [c_aw-1:0]    c_one  = {{(c_aw-1){1'b0}}, 1'b1};

  logic [fifo_width-1:0] r_mem [fifo_depth];
  logic [c_aw-1:0]       rd_ptr;
  logic [c_aw-1:0]       wr_ptr;
  logic [c_aw:0]         cnt;
  logic                  w_rd_en;
  logic                  w_wr_en;

  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == c_full);

  // A write on full is still accepted when a read frees a slot in the same cycle.
  assign w_rd_en = fifo_read && !fifo_empty;
  assign w_wr_en = fifo_write && (!fifo_full || w_rd_en);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[wr_ptr] <= fifo_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      cnt           <= '0;
      fifo_data_out <= '0;
    end else begin
      if (w_wr_en) begin
        wr_ptr <= wr_ptr + c_one;
      end
      if (w_rd_en) begin
        rd_ptr        <= rd_ptr + c_one;
        fifo_data_out <= r_mem[rd_ptr];
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (fifo_write && fifo_full && !fifo_read) begin
        fifo_overflow <= 1'b1;
      end
      if (fifo_read && fifo_empty) begin
        fifo_underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (depth 8, width 8).
`default_nettype none

module tb_fifo_sync;

  logic       clk;
  logic       rst_;
  logic       fifo_write;
  logic       fifo_read;
  logic [7:0] fifo_data_in;
  logic [7:0] fifo_data_out;
  logic       fifo_full;
  logic       fifo_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic       fifo_overflow;
  logic       fifo_underflow;
`endif

  int n_pass;
  int n_total;

  fifo_sync #(.fifo_depth(8), .fifo_width(8)) dut (
    .clk           (clk),
    .rst_          (rst_),
    .fifo_write    (fifo_write),
    .fifo_read     (fifo_read),
    .fifo_data_in  (fifo_data_in),
    .fifo_data_out (fifo_data_out),
    .fifo_full     (fifo_full),
`ifdef FIFO_ERR_FLAGS_EN
    .fifo_overflow (fifo_overflow),
    .fifo_underflow(fifo_underflow),
`endif
    .fifo_empty    (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic op(input logic w, input logic r, input logic [7:0] d);
    fifo_write   = w;
    fifo_read    = r;
    fifo_data_in = d;
    @(posedge clk);
    #1;
    fifo_write   = 1'b0;
    fifo_read    = 1'b0;
    fifo_data_in = 8'h00;
  endtask

  task automatic apply_reset();
    rst_ = 1'b0;
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  task automatic test_reset();
    // Power-on reset
    fifo_write = 1'b0; fifo_read = 1'b0; fifo_data_in = 8'h00;
    rst_ = 1'b0;
    #3;
    n_total++;
    if (dut.cnt !== 4'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_data_out !== 8'h00) begin
      $display("FAIL reset_por: cnt=%0d empty=%b full=%b dout=%h, expected cnt=0 empty=1 full=0 dout=00",
               dut.cnt, fifo_empty, fifo_full, fifo_data_out);
    end else n_pass++;
    @(posedge clk); #1;
    rst_ = 1'b1;
    // Mid-stream reset with cnt=5, no clock edge in between
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(8'hC0 + i));
    op(1'b0, 1'b1, 8'h00);
    op(1'b1, 1'b0, 8'hC5);
    n_total++;
    if (dut.cnt !== 4'd5) begin
      $display("FAIL reset_precnt: cnt=%0d, expected 5", dut.cnt);
    end else n_pass++;
    rst_ = 1'b0;
    #2;
    n_total++;
    if (dut.cnt !== 4'd0 || dut.rd_ptr !== 3'd0 || dut.wr_ptr !== 3'd0 ||
        fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_data_out !== 8'h00) begin
      $display("FAIL reset_async: cnt=%0d rd=%0d wr=%0d empty=%b full=%b dout=%h, expected 0 0 0 1 0 00",
               dut.cnt, dut.rd_ptr, dut.wr_ptr, fifo_empty, fifo_full, fifo_data_out);
    end else n_pass++;
    rst_ = 1'b1;
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      op(1'b1, 1'b0, 8'(i + 1));
      if (i == 6) begin
        n_total++;
        if (fifo_full !== 1'b0) $display("FAIL fill_full7: full=%b, expected 0", fifo_full);
        else n_pass++;
      end
    end
    n_total++;
    if (fifo_full !== 1'b1 || dut.cnt !== 4'd8) begin
      $display("FAIL fill_full8: full=%b cnt=%0d, expected full=1 cnt=8", fifo_full, dut.cnt);
    end else n_pass++;
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 8'h00);
      n_total++;
      if (fifo_data_out !== 8'(i + 1)) begin
        $display("FAIL drain_data[%0d]: dout=%h, expected %h", i, fifo_data_out, 8'(i + 1));
      end else n_pass++;
    end
    n_total++;
    if (fifo_empty !== 1'b1) $display("FAIL drain_empty: empty=%b, expected 1", fifo_empty);
    else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(8'h10 + i));
    op(1'b1, 1'b0, 8'hAA);
    n_total++;
    if (dut.wr_ptr !== 3'd0 || dut.cnt !== 4'd8 || fifo_full !== 1'b1) begin
      $display("FAIL ovf_state: wr=%0d cnt=%0d full=%b, expected wr=0 cnt=8 full=1",
               dut.wr_ptr, dut.cnt, fifo_full);
    end else n_pass++;
`ifdef FIFO_ERR_FLAGS_EN
    n_total++;
    if (fifo_overflow !== 1'b1) $display("FAIL ovf_flag: overflow=%b, expected 1", fifo_overflow);
    else n_pass++;
`endif
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 8'h00);
      n_total++;
      if (fifo_data_out !== 8'(8'h10 + i)) begin
        $display("FAIL ovf_drain[%0d]: dout=%h, expected %h", i, fifo_data_out, 8'(8'h10 + i));
      end else n_pass++;
    end
  endtask

  task automatic test_underflow();
    // Follows test_overflow: empty, rd_ptr wrapped to 0, dout=17
    op(1'b0, 1'b1, 8'h00);
    n_total++;
    if (dut.rd_ptr !== 3'd0 || dut.cnt !== 4'd0 || fifo_data_out !== 8'h17 || fifo_empty !== 1'b1) begin
      $display("FAIL udf_state: rd=%0d cnt=%0d dout=%h empty=%b, expected rd=0 cnt=0 dout=17 empty=1",
               dut.rd_ptr, dut.cnt, fifo_data_out, fifo_empty);
    end else n_pass++;
`ifdef FIFO_ERR_FLAGS_EN
    n_total++;
    if (fifo_underflow !== 1'b1) $display("FAIL udf_flag: underflow=%b, expected 1", fifo_underflow);
    else n_pass++;
`endif
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_q[$];
    apply_reset();
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'(8'h20 + i));
    op(1'b1, 1'b1, 8'h55);
    n_total++;
    if (dut.cnt !== 4'd8 || fifo_full !== 1'b1 || fifo_data_out !== 8'h20) begin
      $display("FAIL sim_full: cnt=%0d full=%b dout=%h, expected cnt=8 full=1 dout=20",
               dut.cnt, fifo_full, fifo_data_out);
    end else n_pass++;
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h55};
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 8'h00);
      n_total++;
      if (fifo_data_out !== exp_q[i]) begin
        $display("FAIL sim_drain[%0d]: dout=%h, expected %h", i, fifo_data_out, exp_q[i]);
      end else n_pass++;
    end
    op(1'b1, 1'b1, 8'h33);
    n_total++;
    if (dut.cnt !== 4'd1 || fifo_data_out !== 8'h55 || fifo_empty !== 1'b0) begin
      $display("FAIL sim_empty: cnt=%0d dout=%h empty=%b, expected cnt=1 dout=55 empty=0",
               dut.cnt, fifo_data_out, fifo_empty);
    end else n_pass++;
    op(1'b0, 1'b1, 8'h00);
    n_total++;
    if (fifo_data_out !== 8'h33 || fifo_empty !== 1'b1) begin
      $display("FAIL sim_read33: dout=%h empty=%b, expected dout=33 empty=1", fifo_data_out, fifo_empty);
    end else n_pass++;
  endtask

  task automatic test_wrap();
    logic [2:0] exp_ptr;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      op(1'b1, 1'b0, 8'(8'h40 + i));
      op(1'b0, 1'b1, 8'h00);
      exp_ptr = 3'((i + 1) % 8);
      n_total++;
      if (fifo_data_out !== 8'(8'h40 + i) || dut.wr_ptr !== exp_ptr || dut.rd_ptr !== exp_ptr) begin
        $display("FAIL wrap[%0d]: dout=%h wr=%0d rd=%0d, expected dout=%h wr=rd=%0d",
                 i, fifo_data_out, dut.wr_ptr, dut.rd_ptr, 8'(8'h40 + i), exp_ptr);
      end else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
